// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: digit-serial adder/subtractor, one 4-bit CLA digit per cycle.
// Define NIBBLE_SERIAL_ADDER_SUB_EN to honour the sub input (A-B); otherwise sub is ignored.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES) + 1;
  localparam logic [1:0] IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif
  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d, s;
  logic [3:0]    ad, bd, g, p;
  logic [4:0]    c;
  assign s         = sub & SUB_EN;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum       = sum_q;
  assign cout      = carry_q;
  always_comb begin
    ad = a_q[{cnt_q, 2'b00} +: 4];
    bd = b_q[{cnt_q, 2'b00} +: 4];
    g  = ad & bd;
    p  = ad ^ bd;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = a;
      b_d     = b ^ {W{s}};
      carry_d = s;
      cnt_d   = '0;
      state_d = ADD;
    end else if (state_q == ADD) begin
      sum_d[{cnt_q, 2'b00} +: 4] = p ^ c[3:0];
      carry_d = c[4];
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(NIBBLES - 1)) ? DONE : ADD;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
    a_q <= a_d;
    b_q <= b_d;
  end
endmodule
